// File: rtl/tdm_demux_pkg.sv
// tdm_demux_pkg: state encoding and default widths shared by the TDM mux/demux pair.
package tdm_demux_pkg;
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
    localparam int DEF_DATA_W = 2;
    localparam int DEF_NUM_CH = 2;
endpackage

// File: rtl/tdm_slot_counter.sv
// tdm_slot_counter: expected channel slot with increment/wrap, load-to-1 and clear.
module tdm_slot_counter #(
    parameter int NUM_CH = 2,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_clr,
    input  logic            i_load1,
    input  logic            i_inc,
    output logic [CH_W-1:0] o_cnt
);
    logic [CH_W-1:0] r_cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_cnt <= '0;
        else if (i_clr) r_cnt <= '0;
        else if (i_load1) r_cnt <= CH_W'(1);
        else if (i_inc) r_cnt <= (r_cnt == CH_W'(NUM_CH - 1)) ? '0 : r_cnt + CH_W'(1);
    end
    assign o_cnt = r_cnt;
endmodule

// File: rtl/tdm_demux.sv
// tdm_demux: steers an interleaved word stream into per-channel holding registers,
// tracking slots from the start-of-frame marker and resynchronising on framing errors.
module tdm_demux
    import tdm_demux_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NUM_CH = DEF_NUM_CH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_sof,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [NUM_CH-1:0]        out_valid,
    output logic                     frame_done,
    output logic                     sync_err,
    output logic                     locked
);
    localparam int CH_W = $clog2(NUM_CH);
    state_t                  r_state, w_nxt;
    logic [NUM_CH*DATA_W-1:0] r_out_data;
    logic [NUM_CH-1:0]       r_out_valid;
    logic                    r_frame_done, r_sync_err;
    logic [CH_W-1:0]         w_cnt, w_idx;
    logic                    w_wr, w_err, w_done, w_clr, w_load, w_inc, w_run, w_zero;

    tdm_slot_counter #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_cnt (
        .clk(clk), .rst(rst), .i_clr(w_clr), .i_load1(w_load), .i_inc(w_inc), .o_cnt(w_cnt)
    );

    assign w_run  = (r_state == RUN);
    assign w_zero = (w_cnt == '0);
    assign w_idx  = in_sof ? '0 : w_cnt;

    always_comb begin
        w_nxt  = r_state;
        w_wr   = 1'b0;
        w_err  = 1'b0;
        w_done = 1'b0;
        w_clr  = 1'b0;
        w_load = 1'b0;
        w_inc  = 1'b0;
        if (in_valid) begin
            if (in_sof) begin
                // SOF always restarts at ch0; mid-frame SOF is flagged but still accepted
                w_wr   = 1'b1;
                w_load = 1'b1;
                w_nxt  = RUN;
                w_err  = w_run && !w_zero;
            end else if (w_run && !w_zero) begin
                w_wr   = 1'b1;
                w_inc  = 1'b1;
                w_done = (w_cnt == CH_W'(NUM_CH - 1));
            end else if (w_run) begin
                w_err  = 1'b1;
                w_clr  = 1'b1;
                w_nxt  = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_out_data   <= '0;
            r_out_valid  <= '0;
            r_frame_done <= 1'b0;
            r_sync_err   <= 1'b0;
        end else begin
            r_state      <= w_nxt;
            if (w_wr) r_out_data[w_idx*DATA_W +: DATA_W] <= in_data;
            r_out_valid  <= w_wr ? (NUM_CH'(1) << w_idx) : '0;
            r_frame_done <= w_done;
            r_sync_err   <= w_err;
        end
    end

    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    assign frame_done = r_frame_done;
    assign sync_err   = r_sync_err;
    assign locked     = w_run;
endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: directed checks of a 2-channel and a 4-channel demux driven by the same stream.
module tb_tdm_demux;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [1:0] in_data = 2'b00;
    logic       in_sof = 1'b0;
    logic [3:0] od2;
    logic [1:0] ov2;
    logic       fd2, se2, lk2;
    logic [7:0] od4;
    logic [3:0] ov4;
    logic       fd4, se4, lk4;
    int         n_pass = 0;
    int         n_total = 0;

    always #5 clk = ~clk;

    tdm_demux u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_sof(in_sof),
        .out_data(od2), .out_valid(ov2), .frame_done(fd2), .sync_err(se2), .locked(lk2)
    );

    tdm_demux #(.DATA_W(2), .NUM_CH(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_sof(in_sof),
        .out_data(od4), .out_valid(ov4), .frame_done(fd4), .sync_err(se4), .locked(lk4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step(input logic v, input logic sof, input logic [1:0] d);
        in_valid = v;
        in_sof   = sof;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data", od2, 0);
        chk("rst_valid", ov2, 0);
        chk("rst_locked", lk2, 0);
        chk("rst_err", se2, 0);
        chk("rst_done", fd2, 0);
        rst = 1'b0;

        step(1, 0, 2'b11);
        chk("idle_drop_valid", ov2, 0);
        chk("idle_drop_locked", lk2, 0);
        chk("idle_drop_data", od2, 0);

        step(1, 1, 2'b01);
        chk("f1_w0_valid", ov2, 2'b01);
        chk("f1_w0_locked", lk2, 1);
        chk("f1_w0_data", od2, 4'b0001);
        step(1, 0, 2'b10);
        chk("f1_w1_valid", ov2, 2'b10);
        chk("f1_w1_done", fd2, 1);
        chk("f1_w1_data", od2, 4'b1001);
        chk("f1_w1_locked", lk2, 1);

        step(1, 1, 2'b00);
        chk("g_w0_valid", ov2, 2'b01);
        chk("g_w0_data", od2, 4'b1000);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 2'b11);
            chk("gap_valid", ov2, 0);
            chk("gap_done", fd2, 0);
            chk("gap_data", od2, 4'b1000);
        end
        step(1, 0, 2'b11);
        chk("g_w1_valid", ov2, 2'b10);
        chk("g_w1_done", fd2, 1);
        chk("g_w1_data", od2, 4'b1100);
        step(1, 1, 2'b01);
        chk("b2b_w0_valid", ov2, 2'b01);
        chk("b2b_w0_err", se2, 0);
        chk("b2b_w0_data", od2, 4'b1101);
        step(1, 0, 2'b10);
        chk("b2b_w1_done", fd2, 1);
        chk("b2b_w1_err", se2, 0);
        chk("b2b_w1_data", od2, 4'b1001);

        step(1, 0, 2'b11);
        chk("miss_err", se2, 1);
        chk("miss_locked", lk2, 0);
        chk("miss_valid", ov2, 0);
        chk("miss_data", od2, 4'b1001);
        step(0, 0, 2'b00);
        chk("miss_err_pulse", se2, 0);

        do_reset();
        step(1, 1, 2'd0);
        chk("e_w0_valid4", ov4, 4'b0001);
        step(1, 0, 2'd1);
        chk("e_w1_valid4", ov4, 4'b0010);
        chk("e_w1_data4", od4, 8'h04);
        step(1, 1, 2'd2);
        chk("early_err4", se4, 1);
        chk("early_valid4", ov4, 4'b0001);
        chk("early_done4", fd4, 0);
        chk("early_locked4", lk4, 1);
        chk("early_data4", od4, 8'h06);
        step(1, 0, 2'd3);
        chk("resync_valid4", ov4, 4'b0010);
        chk("resync_data4", od4, 8'h0E);
        chk("resync_err4", se4, 0);
        chk("dut2_after_seq", od2, 4'b1110);

        step(1, 1, 2'b11);
        chk("mid_w0_data", od2, 4'b1111);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_data", od2, 0);
        chk("async_rst_locked", lk2, 0);
        chk("async_rst_data4", od4, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        step(1, 0, 2'b01);
        chk("post_rst_valid", ov2, 0);
        chk("post_rst_locked", lk2, 0);
        chk("post_rst_data", od2, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Time-division demultiplexer: the receive-side counterpart of the 2:1 word mux.
- Accepts a single interleaved word stream and a start-of-frame marker, tracks the channel slot with an internal counter, and steers each word into a per-channel holding register with a valid pulse.
- Detects framing errors and resynchronises. Sits downstream of the mux/serial link, ahead of the per-channel consumers.

Parameters:
- DATA_W, 2, width of each channel word (matches mux data width).
- NUM_CH, 2, number of channels per frame (>=2).
- CH_W, $clog2(NUM_CH), local parameter (not overridable): channel index width.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data/in_sof valid this cycle.
- in_data  input  DATA_W  interleaved channel word.
- in_sof  input  1  qualifies in_data as the channel-0 word of a new frame.
- out_data  output  NUM_CH*DATA_W  per-channel holding registers; channel k occupies bits [k*DATA_W +: DATA_W].
- out_valid  output  NUM_CH  one-cycle pulse per channel when its register is updated.
- frame_done  output  1  one-cycle pulse when the last channel of a frame is written.
- sync_err  output  1  one-cycle pulse on a framing violation.
- locked  output  1  high while the FSM is in RUN.

Behaviour:
- Reset (async assert, sync release): state=IDLE, ch_cnt=0, out_data=0, out_valid=0, frame_done=0, sync_err=0, locked=0.
- Latency: every output is registered. An accepted word appears in out_data, with its out_valid pulse, on the cycle after the in_valid edge.
- out_data[k] holds its value until channel k is next written. No other event clears it except reset.
- States: IDLE and RUN. ch_cnt is the expected slot, 0..NUM_CH-1.
- IDLE, in_valid & !in_sof: word dropped, no pulses.
- IDLE, in_valid & in_sof: write ch0, pulse out_valid[0], ch_cnt<=1, go to RUN.
- RUN, in_valid & !in_sof & ch_cnt!=0: write channel ch_cnt and pulse out_valid[ch_cnt].
  - If ch_cnt==NUM_CH-1: pulse frame_done and set ch_cnt<=0 (wrap). Otherwise ch_cnt<=ch_cnt+1.
- RUN, in_valid & in_sof & ch_cnt==0: normal new frame. Write ch0, pulse out_valid[0], ch_cnt<=1.
- RUN, in_valid & in_sof & ch_cnt!=0 (early SOF): pulse sync_err, then resynchronise.
  - Write ch0, pulse out_valid[0], ch_cnt<=1, stay in RUN. No frame_done for the truncated frame.
- RUN, in_valid & !in_sof & ch_cnt==0 (missing SOF): pulse sync_err, drop the word, ch_cnt<=0, go to IDLE.
- in_valid=0: no state change and no pulses; gaps are allowed anywhere in a frame.
- in_sof is ignored when in_valid=0.
- Only one word is accepted per cycle, so out_valid is at most one-hot.
- frame_done and the final out_valid[NUM_CH-1] pulse in the same cycle.
- Reset asserted mid-frame: all state and outputs clear immediately. The first word after release must carry in_sof.
- locked = (state==RUN).

Decomposition:
- Shared package holds the state encoding (IDLE=1'b0, RUN=1'b1) and default DATA_W/NUM_CH constants, so they are shared with the mux side.
- One natural sub-module: tdm_slot_counter, covering the ch_cnt register with increment, wrap at NUM_CH-1, load-to-1 and clear.
- Top level holds the FSM, the write-enable decode and the output registers.

Test Plan:
- Reset then IDLE drop: rst=1→0; in_valid=1, in_sof=0, in_data=2'b11 → no out_valid, locked=0, out_data=0.
- Normal frame: (sof,2'b01), then (2'b10).
  - Cycle after each word: out_valid=2'b01, then out_valid=2'b10 with frame_done=1.
  - out_data={2'b10,2'b01}, locked=1.
- Gaps and back-to-back frames:
  - Input: (sof,2'b00), idle 3 cycles, (2'b11), (sof,2'b01), (2'b10).
  - Expect two frame_done pulses, no sync_err, final out_data={2'b10,2'b01}.
- Missing SOF: after a complete frame, send (no sof,2'b11) → sync_err=1, locked=0 next cycle, out_data unchanged.
- Early SOF (NUM_CH=4): (sof,0),(1),(sof,2) → sync_err with out_valid[0] on the third word, ch_cnt=1, no frame_done.
- Reset mid-frame: (sof,2'b11), then assert rst → out_data=0 and locked=0 asynchronously. After release, (2'b01) without sof is dropped.
